// File: rtl/mem_stage_bus_if_if.sv
// -----------------------------------------------------------------------------
// mem_stage_bus_if_if
// Request/acknowledge bus between the MEM-stage bus interface (master) and a
// variable-latency data memory (slave).
//
// Signals:
//   bus_req    master->slave  access request, held until bus_ack is sampled
//   bus_we     master->slave  1 = write, 0 = read
//   bus_addr   master->slave  word-aligned byte address
//   bus_be     master->slave  byte enables, lane i = bits [8i+7:8i]
//   bus_wdata  master->slave  lane-replicated store data
//   bus_ack    slave->master  access complete (only meaningful with bus_req)
//   bus_rdata  slave->master  read data, valid in the bus_ack cycle
// -----------------------------------------------------------------------------
interface mem_stage_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_stage_bus_if.sv
// -----------------------------------------------------------------------------
// mem_stage_bus_if
// MEM-stage bus interface for the 5-stage MIPS R2000 pipeline. Converts the
// EX_MEM load/store request into a request/acknowledge bus transaction to a
// variable-latency memory, steering store bytes onto lanes, extracting and
// extending load data, flagging misaligned accesses and aborting accesses
// that see no acknowledge within TIMEOUT request cycles. The pipeline is
// stalled from detection until the completing (DONE) cycle.
//
// Parameters:
//   TIMEOUT           max REQ cycles without bus_ack before abort (1..255)
//
// Ports:
//   clk               pipeline clock, rising edge
//   rst               synchronous active-high reset
//   mem_read_in[1:0]  load size  (00 none, 01 byte, 10 half, 11 word)
//   mem_write_in[1:0] store size (same encoding, wins over a load)
//   load_unsigned_in  1 = zero-extend loads, 0 = sign-extend
//   addr_in[31:0]     byte address
//   wdata_in[31:0]    store data
//   stall_out         freezes PC and all pipeline registers
//   rdata_out[31:0]   aligned/extended load data (held until next load)
//   rdata_valid_out   one-cycle pulse in the completing cycle of a load
//   misalign_out      one-cycle pulse on a misaligned half/word access
//   bus_err_out       one-cycle pulse when an access timed out
//   bus               master side of mem_stage_bus_if_if
// -----------------------------------------------------------------------------
module mem_stage_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mem_read_in,
    input  logic [1:0]         mem_write_in,
    input  logic               load_unsigned_in,
    input  logic [31:0]        addr_in,
    input  logic [31:0]        wdata_in,
    output logic               stall_out,
    output logic [31:0]        rdata_out,
    output logic               rdata_valid_out,
    output logic               misalign_out,
    output logic               bus_err_out,
    mem_stage_bus_if_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Counter value during the last permitted REQ cycle.
    localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT - 32'd1);

    // Byte enables for an access of the given size at the given lane offset.
    function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                                input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data so every enabled lane carries the right byte.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            SZ_WORD: d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        uns,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h}    : {{16{h[15]}}, h};
            SZ_WORD: r = rdata;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;

    logic        is_write_s;
    logic [1:0]  size_s;
    logic        access_s;
    logic        misalign_s;
    logic        issue_s;
    logic        timeout_s;

    logic [7:0]  cnt_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;
    logic [1:0]  ld_size_r;
    logic [1:0]  ld_lo_r;
    logic        ld_unsigned_r;
    logic        is_load_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic        stall_s;
    logic        req_s;
    logic        valid_s;
    logic        err_s;
    logic        misalign_o_s;

    // Decode the EX_MEM request: a store takes precedence over a load.
    always_comb begin
        is_write_s = (mem_write_in != SZ_NONE);
        if (is_write_s) begin
            size_s = mem_write_in;
        end else begin
            size_s = mem_read_in;
        end
        access_s = (size_s != SZ_NONE);
        case (size_s)
            SZ_HALF: misalign_s = addr_in[0];
            SZ_WORD: misalign_s = (addr_in[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        issue_s   = access_s & ~misalign_s;
        timeout_s = (cnt_r == TIMEOUT_LAST_C);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ack beats a simultaneous timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode. Stall in IDLE is combinational so the pipeline freezes
    // in the very cycle the access is detected.
    always_comb begin
        stall_s      = 1'b0;
        req_s        = 1'b0;
        valid_s      = 1'b0;
        err_s        = 1'b0;
        misalign_o_s = 1'b0;
        if (rst) begin
            stall_s      = 1'b0;
            req_s        = 1'b0;
            valid_s      = 1'b0;
            err_s        = 1'b0;
            misalign_o_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_s      = issue_s;
                    misalign_o_s = access_s & misalign_s;
                end
                ST_REQ: begin
                    stall_s = 1'b1;
                    req_s   = 1'b1;
                end
                ST_DONE: begin
                    valid_s = is_load_r;
                    err_s   = err_r;
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch the bus request at issue, count wait cycles, capture
    // load data on ack (or force it to zero on timeout).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= 8'd0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= 32'h0000_0000;
            bus_be_r      <= 4'b0000;
            bus_wdata_r   <= 32'h0000_0000;
            ld_size_r     <= 2'b00;
            ld_lo_r       <= 2'b00;
            ld_unsigned_r <= 1'b0;
            is_load_r     <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        cnt_r         <= 8'd0;
                        err_r         <= 1'b0;
                        bus_we_r      <= is_write_s;
                        bus_addr_r    <= {addr_in[31:2], 2'b00};
                        bus_be_r      <= lane_enables(size_s, addr_in[1:0]);
                        bus_wdata_r   <= is_write_s ? store_lanes(size_s, wdata_in)
                                                    : 32'h0000_0000;
                        ld_size_r     <= size_s;
                        ld_lo_r       <= addr_in[1:0];
                        ld_unsigned_r <= load_unsigned_in;
                        is_load_r     <= ~is_write_s;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        if (is_load_r) begin
                            rdata_r <= load_extract(ld_size_r, ld_lo_r,
                                                    ld_unsigned_r, bus.bus_rdata);
                        end
                    end else if (timeout_s) begin
                        err_r <= 1'b1;
                        if (is_load_r) begin
                            rdata_r <= 32'h0000_0000;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    err_r <= 1'b0;
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_out       = stall_s;
    assign rdata_out       = rdata_r;
    assign rdata_valid_out = valid_s;
    assign misalign_out    = misalign_o_s;
    assign bus_err_out     = err_s;

    assign bus.bus_req     = req_s;
    assign bus.bus_we      = bus_we_r;
    assign bus.bus_addr    = bus_addr_r;
    assign bus.bus_be      = bus_be_r;
    assign bus.bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_mem_stage_bus_if.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_bus_if
// Self-checking bench for mem_stage_bus_if (TIMEOUT = 4). A behavioural model
// derives byte enables, lane data, load results and cycle counts from the
// access size/offset arithmetic; the bench plays the memory slave.
// -----------------------------------------------------------------------------
module tb_mem_stage_bus_if;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_read_in = 2'b00;
    logic [1:0]  mem_write_in = 2'b00;
    logic        load_unsigned_in = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] wdata_in = 32'h0;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        rdata_valid_out;
    logic        misalign_out;
    logic        bus_err_out;

    mem_stage_bus_if_if bus_i ();

    mem_stage_bus_if #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .load_unsigned_in (load_unsigned_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .stall_out        (stall_out),
        .rdata_out        (rdata_out),
        .rdata_valid_out  (rdata_valid_out),
        .misalign_out     (misalign_out),
        .bus_err_out      (bus_err_out),
        .bus              (bus_i)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_seen = 0;
    int          exp_acks = 0;
    logic [31:0] exp_rdata = 32'h0;

    // Count completed bus handshakes to prove each access issues exactly once.
    always @(posedge clk) begin
        if (!rst && bus_i.bus_req && bus_i.bus_ack) ack_seen <= ack_seen + 1;
    end

    initial begin
        bus_i.bus_ack   = 1'b0;
        bus_i.bus_rdata = 32'h0;
    end

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [1:0] size);
        return 1 << (int'(size) - 1);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int lo, n;
        be = 4'b0000;
        lo = int'(addr[1:0]);
        n  = m_bytes(size);
        for (int i = 0; i < 4; i++) if (i >= lo && i < lo + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = m_bytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic uns, input logic [31:0] rd);
        logic [63:0] mask, v;
        int n;
        n    = m_bytes(size);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = ({32'h0, rd} >> (8 * int'(addr[1:0]))) & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One EX_MEM access; waits < 0 means the slave never acknowledges.
    task automatic run_access(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input string tag);
        logic [1:0] size;
        logic is_wr, is_ld, mis, to_exp;
        int req_cycles, stalls, exp_req;
        is_wr = (wr != 2'b00);
        size  = is_wr ? wr : rd;
        is_ld = !is_wr;
        mis   = (int'(addr[1:0]) % m_bytes(size)) != 0;
        mem_read_in = rd; mem_write_in = wr; load_unsigned_in = uns;
        addr_in = addr; wdata_in = wdata; bus_i.bus_ack = 1'b0;
        #1;
        n_vec++; if (misalign_out !== mis) begin n_err++; $display("FAIL %s misalign: got %b want %b", tag, misalign_out, mis); end
        if (mis) begin
            n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL %s mis_stall: got %b want 0", tag, stall_out); end
            @(negedge clk);
            mem_read_in = 2'b00; mem_write_in = 2'b00;
            #1;
            n_vec++; if (bus_i.bus_req !== 1'b0) begin n_err++; $display("FAIL %s mis_req: got %b want 0", tag, bus_i.bus_req); end
            n_vec++; if (misalign_out !== 1'b0) begin n_err++; $display("FAIL %s mis_pulse: got %b want 0", tag, misalign_out); end
            n_vec++; if (rdata_out !== exp_rdata) begin n_err++; $display("FAIL %s mis_rdata: got %h want %h", tag, rdata_out, exp_rdata); end
            return;
        end
        n_vec++; if (stall_out !== 1'b1 || bus_i.bus_req !== 1'b0) begin n_err++; $display("FAIL %s detect: got stall=%b req=%b want stall=1 req=0", tag, stall_out, bus_i.bus_req); end
        stalls = 1; req_cycles = 0;
        @(negedge clk);
        while (bus_i.bus_req === 1'b1 && req_cycles < 20) begin
            req_cycles++;
            if (stall_out === 1'b1) stalls++;
            n_vec++; if (bus_i.bus_we !== is_wr) begin n_err++; $display("FAIL %s we: got %b want %b", tag, bus_i.bus_we, is_wr); end
            n_vec++; if (bus_i.bus_addr !== {addr[31:2], 2'b00}) begin n_err++; $display("FAIL %s addr: got %h want %h", tag, bus_i.bus_addr, {addr[31:2], 2'b00}); end
            n_vec++; if (bus_i.bus_be !== m_be(size, addr)) begin n_err++; $display("FAIL %s be: got %b want %b", tag, bus_i.bus_be, m_be(size, addr)); end
            if (is_wr) begin
                n_vec++; if (bus_i.bus_wdata !== m_wdata(size, wdata)) begin n_err++; $display("FAIL %s wdata: got %h want %h", tag, bus_i.bus_wdata, m_wdata(size, wdata)); end
            end
            if (waits >= 0 && req_cycles == waits + 1) begin
                bus_i.bus_ack = 1'b1; bus_i.bus_rdata = rdata;
            end else begin
                bus_i.bus_ack = 1'b0; bus_i.bus_rdata = $urandom;
            end
            @(negedge clk);
        end
        bus_i.bus_ack = 1'b0;
        to_exp  = (waits < 0) || (waits + 1 > TO);
        exp_req = to_exp ? TO : waits + 1;
        if (!to_exp) exp_acks++;
        if (is_ld) exp_rdata = to_exp ? 32'h0 : m_load(size, addr, uns, rdata);
        n_vec++; if (req_cycles !== exp_req) begin n_err++; $display("FAIL %s req_cycles: got %0d want %0d", tag, req_cycles, exp_req); end
        n_vec++; if (stalls !== exp_req + 1) begin n_err++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_req + 1); end
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL %s done_stall: got %b want 0", tag, stall_out); end
        n_vec++; if (rdata_valid_out !== is_ld) begin n_err++; $display("FAIL %s valid: got %b want %b", tag, rdata_valid_out, is_ld); end
        n_vec++; if (bus_err_out !== to_exp) begin n_err++; $display("FAIL %s bus_err: got %b want %b", tag, bus_err_out, to_exp); end
        n_vec++; if (rdata_out !== exp_rdata) begin n_err++; $display("FAIL %s rdata: got %h want %h", tag, rdata_out, exp_rdata); end
        @(negedge clk);
        mem_read_in = 2'b00; mem_write_in = 2'b00;
        #1;
        n_vec++; if (rdata_valid_out !== 1'b0 || bus_err_out !== 1'b0 || stall_out !== 1'b0 || bus_i.bus_req !== 1'b0)
            begin n_err++; $display("FAIL %s after_done: got valid=%b err=%b stall=%b req=%b want all 0", tag, rdata_valid_out, bus_err_out, stall_out, bus_i.bus_req); end
        n_vec++; if (rdata_out !== exp_rdata) begin n_err++; $display("FAIL %s rdata_hold: got %h want %h", tag, rdata_out, exp_rdata); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        mem_read_in = 2'b11; addr_in = 32'h0000_0100;
        @(negedge clk); @(negedge clk);
        #1;
        n_vec++; if (stall_out !== 1'b0 || bus_i.bus_req !== 1'b0) begin n_err++; $display("FAIL reset_forced: got stall=%b req=%b want 0 0", stall_out, bus_i.bus_req); end
        n_vec++; if ({rdata_out, rdata_valid_out, misalign_out, bus_err_out} !== 35'h0) begin n_err++; $display("FAIL reset_outs: got rdata=%h v=%b m=%b e=%b want 0", rdata_out, rdata_valid_out, misalign_out, bus_err_out); end
        n_vec++; if ({bus_i.bus_we, bus_i.bus_addr, bus_i.bus_be, bus_i.bus_wdata} !== 69'h0) begin n_err++; $display("FAIL reset_bus: got we=%b a=%h be=%b wd=%h want 0", bus_i.bus_we, bus_i.bus_addr, bus_i.bus_be, bus_i.bus_wdata); end
        mem_read_in = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        run_access(2'b11, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, "word_load");
    endtask

    task automatic test_byte_loads();
        run_access(2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, "lb_signed");
        run_access(2'b01, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, "lbu");
        run_access(2'b10, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h8012_3456, 0, "lh_signed");
    endtask

    task automatic test_half_store();
        run_access(2'b00, 2'b10, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, "half_store");
    endtask

    task automatic test_misaligned();
        run_access(2'b11, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h1111_2222, 0, "mis_word");
        run_access(2'b00, 2'b10, 1'b0, 32'h0000_0203, 32'h1234, 32'h0, 0, "mis_half_st");
    endtask

    task automatic test_timeout();
        run_access(2'b11, 2'b00, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, -1, "timeout");
        bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_i.bus_ack = 1'b0;
        #1;
        n_vec++; if (bus_i.bus_req !== 1'b0 || rdata_valid_out !== 1'b0 || rdata_out !== exp_rdata)
            begin n_err++; $display("FAIL late_ack: got req=%b valid=%b rdata=%h want 0 0 %h", bus_i.bus_req, rdata_valid_out, rdata_out, exp_rdata); end
        run_access(2'b11, 2'b00, 1'b0, 32'h0000_0304, 32'h0, 32'h0BAD_CAFE, 3, "ack_at_limit");
    endtask

    task automatic test_back_to_back();
        int acks_before;
        acks_before = exp_acks;
        run_access(2'b00, 2'b01, 1'b0, 32'h0000_0401, 32'h0000_00A5, 32'h0, 0, "b2b_store");
        run_access(2'b01, 2'b00, 1'b1, 32'h0000_0401, 32'h0, 32'h0000_A500, 0, "b2b_load");
        n_vec++; if (exp_acks - acks_before !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", exp_acks - acks_before); end
    endtask

    task automatic test_reset_mid_req();
        mem_read_in = 2'b11; addr_in = 32'h0000_0500; bus_i.bus_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        n_vec++; if (bus_i.bus_req !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b want 1", bus_i.bus_req); end
        rst = 1'b1;
        #1;
        n_vec++; if (stall_out !== 1'b0 || bus_i.bus_req !== 1'b0) begin n_err++; $display("FAIL rmid_forced: got stall=%b req=%b want 0 0", stall_out, bus_i.bus_req); end
        @(negedge clk);
        #1;
        n_vec++; if ({bus_i.bus_req, bus_i.bus_we, bus_i.bus_addr, bus_i.bus_be, bus_i.bus_wdata} !== 70'h0)
            begin n_err++; $display("FAIL rmid_bus: got req=%b a=%h be=%b want 0", bus_i.bus_req, bus_i.bus_addr, bus_i.bus_be); end
        n_vec++; if ({stall_out, rdata_out, rdata_valid_out, misalign_out, bus_err_out} !== 36'h0)
            begin n_err++; $display("FAIL rmid_outs: got stall=%b rdata=%h v=%b want 0", stall_out, rdata_out, rdata_valid_out); end
        mem_read_in = 2'b00; rst = 1'b0; exp_rdata = 32'h0;
        bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_i.bus_ack = 1'b0;
        #1;
        n_vec++; if (bus_i.bus_req !== 1'b0 || rdata_valid_out !== 1'b0 || rdata_out !== 32'h0)
            begin n_err++; $display("FAIL rmid_late_ack: got req=%b valid=%b rdata=%h want 0 0 0", bus_i.bus_req, rdata_valid_out, rdata_out); end
        run_access(2'b10, 2'b00, 1'b0, 32'h0000_0502, 32'h0, 32'hF00F_1234, 1, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0] sz, rd, wr;
        logic [31:0] a;
        int r;
        for (int k = 0; k < 60; k++) begin
            r  = $urandom_range(0, 9);
            sz = 2'($urandom_range(1, 3));
            a  = $urandom;
            if (r != 9) a = a & ~(32'(m_bytes(sz)) - 32'd1);
            rd = 2'b00; wr = 2'b00;
            if (r < 4) wr = sz;
            else if (r == 8) begin wr = sz; rd = 2'($urandom_range(1, 3)); end
            else rd = sz;
            run_access(rd, wr, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                       $urandom_range(0, 5), "random");
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        @(negedge clk);
        n_vec++; if (ack_seen !== exp_acks) begin n_err++; $display("FAIL ack_count: got %0d want %0d", ack_seen, exp_acks); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
